// File: rtl/drum_pkg.sv
// Shared definitions for the drum voices, the mixer and the top level:
// instrument encodings, default timing constants and the voice FSM states.
package drum_pkg;

    localparam logic [1:0] SEL_KICK  = 2'd0;
    localparam logic [1:0] SEL_SNARE = 2'd1;
    localparam logic [1:0] SEL_HAT   = 2'd2;
    localparam logic [1:0] SEL_CLAP  = 2'd3;

    // 50 MHz system clock divided down to an 8 kHz audio sample rate.
    localparam int CLK_DIV_8K     = 6250;
    localparam int SAMPLE_LEN_DEF = 12000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } voice_state_t;

endpackage

// File: rtl/drum_voice_if.sv
// Bundle between one drum voice and its surroundings: sequencer controls,
// the external synchronous sample ROM and the mixer-facing sample stream.
interface drum_voice_if #(
    parameter int IDX_W = 14
);
    logic             en;
    logic             go;
    logic [1:0]       sel;
    logic [IDX_W+1:0] rom_addr;
    logic [7:0]       rom_data;   // two's-complement PCM
    logic [7:0]       out;        // two's-complement PCM, 0 when silent
    logic             out_valid;
    logic             busy;

    // Environment side: sequencer, ROM and mixer.
    modport master (
        output en, go, sel, rom_data,
        input  rom_addr, out, out_valid, busy
    );

    // Voice side.
    modport slave (
        input  en, go, sel, rom_data,
        output rom_addr, out, out_valid, busy
    );
endinterface

// File: rtl/sample_rate_div.sv
// Audio sample-rate divider: counts 0..CLK_DIV-1 while enabled and flags the
// last count as tick. Synchronous clear has priority over counting.
module sample_rate_div #(
    parameter int CLK_DIV = 6250
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick,
    output logic zero
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en & (cnt == LAST);
    assign zero = (cnt == '0);

    // Divider counter, wraps to zero after the tick cycle.
    // NOTE: asynchronous reset appears in the sensitivity list so registers clear without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/drum_voice.sv
// One-shot drum sample player. A rising edge on go (while en is high)
// streams one instrument's sample from the external ROM at the audio rate.
// Retriggers restart the sample; en low silences the voice immediately.
module drum_voice
    import drum_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_8K,
    parameter int IDX_W      = 14,
    parameter int SAMPLE_LEN = SAMPLE_LEN_DEF
) (
    input  logic         clk,
    input  logic         reset,
    drum_voice_if.slave  voice
);
    voice_state_t     state, state_next;
    logic             go_q;
    logic             trig;
    logic             tick;
    logic             div_zero;
    logic             playing;
    logic             last;
    logic             end_tick;
    logic             fetch;
    logic [IDX_W-1:0] idx;
    logic [1:0]       sel_q;
    logic [7:0]       out_r;
    logic             out_valid_r;

    assign trig     = voice.en & voice.go & ~go_q;
    assign playing  = (state == ST_PLAY);
    assign last     = (idx == IDX_W'(SAMPLE_LEN - 1));
    // A trigger on the final tick restarts instead of ending the sample.
    assign end_tick = playing & tick & last & ~trig;

    // Divider is held at zero whenever the voice is idle, disabled or restarting.
    sample_rate_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .clr   (trig | ~voice.en | ~playing),
        .en    (playing),
        .tick  (tick),
        .zero  (div_zero)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // FSM next-state: trigger wins over disable and end of sample.
    // NOTE: next state gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (trig) state_next = ST_PLAY;
            ST_PLAY: begin
                if (trig)             state_next = ST_PLAY;
                else if (!voice.en)   state_next = ST_IDLE;
                else if (tick && last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Sample index, captured bank, ROM fetch pipeline and output register.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            go_q        <= 1'b0;
            idx         <= '0;
            sel_q       <= '0;
            fetch       <= 1'b0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            go_q        <= voice.go;
            out_valid_r <= 1'b0;
            // The address changes exactly when the divider restarts at zero;
            // its ROM data is valid one cycle later, which is when fetch is set.
            fetch       <= playing & voice.en & div_zero & ~trig & ~(tick & last);

            if (trig) begin
                idx   <= '0;
                sel_q <= voice.sel;
            end else if (playing && voice.en && tick && !last) begin
                idx <= idx + 1'b1;
            end

            if (!voice.en) begin
                out_r       <= '0;
                out_valid_r <= |out_r;
            end else if (end_tick) begin
                out_r       <= '0;
                out_valid_r <= 1'b1;
            end else if (fetch && !trig) begin
                // An in-flight fetch is dropped when a retrigger lands on it.
                out_r       <= voice.rom_data;
                out_valid_r <= 1'b1;
            end
        end
    end

    assign voice.rom_addr  = {sel_q, idx};
    assign voice.out       = out_r;
    assign voice.out_valid = out_valid_r;
    assign voice.busy      = playing;

endmodule

// File: tb/tb_drum_voice.sv
// Self-checking bench for drum_voice with CLK_DIV=4, SAMPLE_LEN=3, IDX_W=2
// and a ROM returning {addr[3:0], addr[3:0]}. Expected output pulses are
// queued when a trigger is driven and compared as out_valid pulses appear.
module tb_drum_voice;

    localparam int TB_DIV = 4;
    localparam int TB_LEN = 3;
    localparam int TB_IDX = 2;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t sb[$];
    exp_t mon_e;

    drum_voice_if #(.IDX_W(TB_IDX)) voice ();

    drum_voice #(
        .CLK_DIV    (TB_DIV),
        .IDX_W      (TB_IDX),
        .SAMPLE_LEN (TB_LEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .voice (voice)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM model: one cycle of read latency.
    always @(posedge clk) voice.rom_data <= {voice.rom_addr[3:0], voice.rom_addr[3:0]};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic logic [7:0] rom_val(input logic [1:0] s, input int k);
        logic [3:0] a;
        a = {s, k[1:0]};
        return {a, a};
    endfunction

    task automatic push(input logic [7:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Full playback triggered in cycle t: samples at t+3, t+3+DIV, ..., silence after.
    task automatic expect_full(input logic [1:0] s, input int t);
        for (int k = 0; k < TB_LEN; k++) push(rom_val(s, k), t + 3 + TB_DIV * k);
        push(8'h00, t + 1 + TB_DIV * TB_LEN);
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Output monitor: every out_valid pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (voice.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("out_value", voice.out, mon_e.val);
                check("out_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        int t, r, f;
        cyc       = 0;
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        voice.en  = 1'b0;
        voice.go  = 1'b0;
        voice.sel = 2'd0;
        #1 reset = 1'b1;
        #1;
        check("rst_out",       voice.out,       0);
        check("rst_out_valid", voice.out_valid, 0);
        check("rst_busy",      voice.busy,      0);
        check("rst_rom_addr",  voice.rom_addr,  0);
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        voice.en = 1'b1;
        @(negedge clk);

        // Basic play, hat bank.
        t = cyc; voice.sel = 2'd2; voice.go = 1'b1;
        expect_full(2'd2, t);
        at(t + 1);  voice.go = 1'b0;
        check("basic_busy_t1", voice.busy, 1);
        check("basic_addr_t1", voice.rom_addr, 8);
        at(t + 2);  check("basic_out_t2", voice.out, 0);
        at(t + 3);  check("basic_out_t3", voice.out, 8'h88);
        at(t + 5);  check("basic_addr_t5", voice.rom_addr, 9);
        at(t + 9);  check("basic_addr_t9", voice.rom_addr, 10);
        at(t + 12); check("basic_busy_t12", voice.busy, 1);
        at(t + 13); check("basic_busy_t13", voice.busy, 0);
        check("basic_out_t13", voice.out, 0);
        at(t + 16); check("basic_sb_empty", sb.size(), 0);

        // Held trigger: one playback only.
        t = cyc; voice.sel = 2'd3; voice.go = 1'b1;
        expect_full(2'd3, t);
        at(t + 13); check("held_busy_end", voice.busy, 0);
        at(t + 39); check("held_no_restart", voice.busy, 0);
        at(t + 40); voice.go = 1'b0;
        at(t + 43); check("held_sb_empty", sb.size(), 0);

        // Retrigger 6 cycles in with a new bank; later sel changes are ignored.
        t = cyc; voice.sel = 2'd2; voice.go = 1'b1;
        push(8'h88, t + 3);
        at(t + 1); voice.go = 1'b0;
        at(t + 6); voice.sel = 2'd1; voice.go = 1'b1; r = t + 6;
        expect_full(2'd1, r);
        at(r + 1); voice.go = 1'b0;
        check("retrig_addr", voice.rom_addr, 4);
        check("retrig_busy", voice.busy, 1);
        check("retrig_hold_r1", voice.out, 8'h88);
        at(r + 2); voice.sel = 2'd3;
        check("retrig_hold_r2", voice.out, 8'h88);
        at(r + 3); check("retrig_out", voice.out, 8'h44);
        at(r + 5); check("retrig_sel_ignored", voice.rom_addr, 5);
        at(r + 14); check("retrig_idle", voice.busy, 0);
        check("retrig_sb_empty", sb.size(), 0);

        // Disable mid-play during sample 1; a go edge while disabled is ignored.
        t = cyc; voice.sel = 2'd2; voice.go = 1'b1;
        push(8'h88, t + 3);
        push(8'h99, t + 7);
        at(t + 1); voice.go = 1'b0;
        at(t + 8); voice.en = 1'b0; f = t + 8;
        push(8'h00, f + 1);
        at(f + 1); check("dis_busy", voice.busy, 0);
        check("dis_out", voice.out, 0);
        at(f + 3); voice.go = 1'b1;
        at(f + 4); voice.go = 1'b0;
        at(f + 6); check("dis_go_ignored", voice.busy, 0);
        voice.en = 1'b1;
        at(f + 10); check("dis_stays_idle", voice.busy, 0);
        check("dis_sb_empty", sb.size(), 0);

        // Collision: go edge in the cycle of the final tick restarts, busy never drops.
        t = cyc; voice.sel = 2'd2; voice.go = 1'b1;
        for (int k = 0; k < TB_LEN; k++) push(rom_val(2'd2, k), t + 3 + TB_DIV * k);
        at(t + 1); voice.go = 1'b0;
        r = t + TB_DIV * TB_LEN;
        for (int i = t + 1; i <= r + 12; i++) begin
            at(i);
            if (i == r) begin
                voice.sel = 2'd1;
                voice.go  = 1'b1;
            end
            if (i == r + 1) begin
                voice.go = 1'b0;
                check("coll_addr", voice.rom_addr, 4);
                expect_full(2'd1, r);
            end
            check("coll_busy", voice.busy, 1);
        end
        at(r + 13); check("coll_idle", voice.busy, 0);
        at(r + 16); check("coll_sb_empty", sb.size(), 0);

        // Async reset mid-play: outputs clear before any clock edge.
        t = cyc; voice.sel = 2'd3; voice.go = 1'b1;
        push(8'hCC, t + 3);
        push(8'hDD, t + 7);
        at(t + 1); voice.go = 1'b0;
        at(t + 8); check("arst_playing", voice.out, 8'hDD);
        #2 reset = 1'b1;
        sb.delete();
        #1;
        check("arst_out",       voice.out,       0);
        check("arst_out_valid", voice.out_valid, 0);
        check("arst_busy",      voice.busy,      0);
        check("arst_rom_addr",  voice.rom_addr,  0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("arst_post_busy", voice.busy, 0);
        check("arst_post_out",  voice.out,  0);
        check("arst_post_addr", voice.rom_addr, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
